ysyx_23060077_ifu_fetchq: RTL and testbench

YSYX_23060077_IFU_FETCHQ -- requirements
Module: ysyx_23060077_ifu_fetchq

---
 rtl/ysyx_23060077_ifu_fetchq.sv | 146 ++++++++++++++
 tb/tb_ysyx_23060077_ifu_fetchq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060077_ifu_fetchq.sv
// ysyx_23060077_ifu_fetchq: instruction fetch engine issuing burst reads into a small fetch queue
//
// Ports:
//   clk, reset_n                  clock and synchronous active-low reset
//   redirect_valid, redirect_pc   redirect strobe and new fetch address (low two bits ignored)
//   ifu_r_valid_o/arready_i/addr_o/len_o   burst read request channel
//   ifu_r_ready_i/data_i/last_i/err_i      read data beats
//   ifu_valid_o/ready_i/pc_o/inst_o/fault_o  queue head toward decode
//   fq_count_o                    current queue occupancy
module ysyx_23060077_ifu_fetchq #(
    parameter int                 DATA_WIDTH = 32,
    parameter int                 ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h3000_0000,
    parameter int                 FQ_DEPTH   = 4,
    parameter int                 BURST_LEN  = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      redirect_valid,
    input  logic [ADDR_WIDTH-1:0]     redirect_pc,
    output logic                      ifu_r_valid_o,
    input  logic                      ifu_r_arready_i,
    output logic [ADDR_WIDTH-1:0]     ifu_r_addr_o,
    output logic [7:0]                ifu_r_len_o,
    input  logic                      ifu_r_ready_i,
    input  logic [DATA_WIDTH-1:0]     ifu_r_data_i,
    input  logic                      ifu_r_last_i,
    input  logic                      ifu_r_err_i,
    output logic                      ifu_valid_o,
    input  logic                      ifu_ready_i,
    output logic [ADDR_WIDTH-1:0]     ifu_pc_o,
    output logic [DATA_WIDTH-1:0]     ifu_inst_o,
    output logic                      ifu_fault_o,
    output logic [$clog2(FQ_DEPTH):0] fq_count_o
);
    localparam int PW = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int CW = $clog2(FQ_DEPTH) + 1;

    typedef enum logic [2:0] {IDLE, REQ, DATA, DRAIN, HALT} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, req_addr_q, beat_pc_q;
    logic                  r_valid_q, redir_pend_q, halt_pend_q;

    logic [DATA_WIDTH-1:0] inst_mem [FQ_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [FQ_DEPTH];
    logic                  fault_mem[FQ_DEPTH];
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    logic fits, push, pop, unused_pc_lo;
    logic [ADDR_WIDTH-1:0] redir_addr;

    assign redir_addr   = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign unused_pc_lo = ^redirect_pc[1:0];
    // Slots for a whole burst are reserved before issuing, so a push never meets a full queue.
    assign fits = (32'(count_q) + 32'(BURST_LEN)) <= 32'(FQ_DEPTH);
    assign push = (state_q == DATA) && ifu_r_ready_i && !redirect_valid;
    assign pop  = ifu_valid_o && ifu_ready_i && !redirect_valid;

    assign ifu_r_valid_o = r_valid_q;
    assign ifu_r_addr_o  = req_addr_q;
    assign ifu_r_len_o   = 8'(BURST_LEN - 1);
    assign ifu_valid_o   = count_q != '0;
    assign ifu_pc_o      = pc_mem[rd_ptr_q];
    assign ifu_inst_o    = inst_mem[rd_ptr_q];
    assign ifu_fault_o   = ifu_valid_o && fault_mem[rd_ptr_q];
    assign fq_count_o    = count_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            req_addr_q   <= RESET_PC;
            beat_pc_q    <= RESET_PC;
            r_valid_q    <= 1'b0;
            redir_pend_q <= 1'b0;
            halt_pend_q  <= 1'b0;
        end else begin
            if (redirect_valid) fetch_pc_q <= redir_addr;
            case (state_q)
                IDLE: if (!redirect_valid && fits) begin
                    state_q      <= REQ;
                    r_valid_q    <= 1'b1;
                    req_addr_q   <= fetch_pc_q;
                    beat_pc_q    <= fetch_pc_q;
                    redir_pend_q <= 1'b0;
                    halt_pend_q  <= 1'b0;
                end
                // The request address stays on req_addr_q even if fetch_pc moves under a redirect.
                REQ: if (ifu_r_arready_i) begin
                    r_valid_q <= 1'b0;
                    state_q   <= (redirect_valid || redir_pend_q) ? DRAIN : DATA;
                end else if (redirect_valid) begin
                    redir_pend_q <= 1'b1;
                end
                DATA: if (ifu_r_ready_i) begin
                    beat_pc_q <= beat_pc_q + ADDR_WIDTH'(4);
                    // A redirect on the final beat ends the burst; there is nothing left to drain.
                    if (redirect_valid) state_q <= ifu_r_last_i ? IDLE : DRAIN;
                    else if (ifu_r_err_i) begin
                        state_q     <= ifu_r_last_i ? HALT : DRAIN;
                        halt_pend_q <= !ifu_r_last_i;
                    end else if (ifu_r_last_i) begin
                        state_q    <= IDLE;
                        fetch_pc_q <= fetch_pc_q + ADDR_WIDTH'(4 * BURST_LEN);
                    end
                end else if (redirect_valid) begin
                    state_q <= DRAIN;
                end
                DRAIN: begin
                    if (redirect_valid) halt_pend_q <= 1'b0;
                    if (ifu_r_ready_i && ifu_r_last_i) state_q <= (halt_pend_q && !redirect_valid) ? HALT : IDLE;
                end
                HALT: if (redirect_valid) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        rd_ptr_d = redirect_valid ? '0 : rd_ptr_q + PW'(pop);
        wr_ptr_d = redirect_valid ? '0 : wr_ptr_q + PW'(push);
        count_d  = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_q]  <= ifu_r_data_i;
            pc_mem[wr_ptr_q]    <= beat_pc_q;
            fault_mem[wr_ptr_q] <= ifu_r_err_i;
        end
    end
endmodule

// File: tb/tb_ysyx_23060077_ifu_fetchq.sv
// tb_ysyx_23060077_ifu_fetchq: directed and random checks of the fetch queue against a queue-level model
module tb_ysyx_23060077_ifu_fetchq;
    localparam int DEPTH = 4;
    localparam int BL    = 2;
    localparam logic [31:0] RPC = 32'h3000_0000;

    logic        clk = 1'b0, reset_n = 1'b0, redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ifu_r_valid_o, ifu_r_arready_i = 1'b0;
    logic [31:0] ifu_r_addr_o;
    logic [7:0]  ifu_r_len_o;
    logic        ifu_r_ready_i = 1'b0, ifu_r_last_i = 1'b0, ifu_r_err_i = 1'b0;
    logic [31:0] ifu_r_data_i = '0;
    logic        ifu_valid_o, ifu_ready_i = 1'b0, ifu_fault_o;
    logic [31:0] ifu_pc_o, ifu_inst_o;
    logic [2:0]  fq_count_o;

    ysyx_23060077_ifu_fetchq #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(RPC), .FQ_DEPTH(DEPTH), .BURST_LEN(BL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ifu_r_valid_o(ifu_r_valid_o), .ifu_r_arready_i(ifu_r_arready_i), .ifu_r_addr_o(ifu_r_addr_o),
        .ifu_r_len_o(ifu_r_len_o), .ifu_r_ready_i(ifu_r_ready_i), .ifu_r_data_i(ifu_r_data_i),
        .ifu_r_last_i(ifu_r_last_i), .ifu_r_err_i(ifu_r_err_i), .ifu_valid_o(ifu_valid_o),
        .ifu_ready_i(ifu_ready_i), .ifu_pc_o(ifu_pc_o), .ifu_inst_o(ifu_inst_o),
        .ifu_fault_o(ifu_fault_o), .fq_count_o(fq_count_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [31:0] pc; logic [31:0] inst; logic fault;} ent_t;
    ent_t        exp_q[$];
    logic [31:0] m_fpc, m_raddr, m_beat;
    bit          m_out, m_drop, m_halt, m_redir_req;
    int          m_idx;
    int          tests = 0, fails = 0;
    int          p_ar = 0, p_r = 100, p_redir = 0, p_err = 0, p_pop = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_auto();
        redirect_valid  = $urandom_range(99) < p_redir;
        redirect_pc     = $urandom;
        ifu_r_arready_i = $urandom_range(99) < p_ar;
        ifu_r_ready_i   = m_out && ($urandom_range(99) < p_r);
        ifu_r_last_i    = ifu_r_ready_i && (m_idx == BL - 1);
        ifu_r_err_i     = ifu_r_ready_i && ($urandom_range(99) < p_err);
        ifu_r_data_i    = $urandom;
        ifu_ready_i     = $urandom_range(99) < p_pop;
    endtask

    task automatic tick();
        logic rv, redir, pop;
        rv    = ifu_r_valid_o;
        redir = redirect_valid;
        pop   = (exp_q.size() != 0) && ifu_ready_i && !redir;
        if (rv) chk("one_outstanding", m_out, 0);
        @(posedge clk);
        if (rv && redir) m_redir_req = 1;
        if (pop) void'(exp_q.pop_front());
        if (rv && ifu_r_arready_i) begin
            m_out = 1; m_beat = m_raddr; m_idx = 0; m_drop = m_redir_req;
        end else if (m_out && ifu_r_ready_i) begin
            if (!m_drop && !redir) begin
                exp_q.push_back('{m_beat, ifu_r_data_i, ifu_r_err_i});
                if (ifu_r_err_i) begin m_halt = 1; m_drop = 1; end
            end
            if (redir) m_drop = 1;
            if (ifu_r_last_i) begin
                m_out = 0;
                if (!m_drop) m_fpc = m_fpc + 32'(4 * BL);
            end
            m_beat = m_beat + 32'd4;
            m_idx++;
        end else if (m_out && redir) m_drop = 1;
        if (redir) begin
            exp_q.delete();
            m_fpc  = {redirect_pc[31:2], 2'b00};
            m_halt = 0;
        end
        #1;
        chk("count", fq_count_o, exp_q.size());
        chk("valid", ifu_valid_o, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            chk("head_pc", ifu_pc_o, exp_q[0].pc);
            chk("head_inst", ifu_inst_o, exp_q[0].inst);
            chk("head_fault", ifu_fault_o, exp_q[0].fault);
        end else chk("empty_fault", ifu_fault_o, 0);
        if (ifu_r_valid_o && !rv) begin
            chk("req_addr", ifu_r_addr_o, m_fpc);
            chk("req_len", ifu_r_len_o, BL - 1);
            chk("req_allowed", {m_halt, m_out, exp_q.size() + BL > DEPTH}, 0);
            m_raddr     = ifu_r_addr_o;
            m_redir_req = 0;
        end else if (ifu_r_valid_o) chk("req_hold", ifu_r_addr_o, m_raddr);
    endtask

    task automatic run(int n);
        repeat (n) begin drive_auto(); tick(); end
    endtask

    task automatic wait_req(int budget, string tag);
        int n = 0;
        while (!ifu_r_valid_o && n < budget) begin drive_auto(); tick(); n++; end
        chk(tag, ifu_r_valid_o, 1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; redirect_valid = 1'b0; ifu_r_arready_i = 1'b0; ifu_r_ready_i = 1'b0;
        ifu_r_last_i = 1'b0; ifu_r_err_i = 1'b0; ifu_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rvalid", ifu_r_valid_o, 0);
        chk("rst_valid", ifu_valid_o, 0);
        chk("rst_fault", ifu_fault_o, 0);
        chk("rst_count", fq_count_o, 0);
        exp_q.delete();
        m_fpc = RPC; m_out = 0; m_drop = 0; m_halt = 0; m_redir_req = 0; m_idx = 0;
        reset_n = 1'b1;
        chk("rise_rvalid", ifu_r_valid_o, 0);
        drive_auto();
        redirect_valid = 1'b0; ifu_r_arready_i = 1'b0;
        tick();
        chk("first_req", ifu_r_valid_o, 1);
        chk("first_addr", ifu_r_addr_o, RPC);
        chk("first_len", ifu_r_len_o, 1);
    endtask

    initial begin
        do_reset();
        // back-to-back bursts with immediate handshakes and no consumer
        p_ar = 100; p_r = 100; p_pop = 0;
        run(4);
        chk("two_beats", fq_count_o, 2);
        chk("second_req", ifu_r_addr_o, 32'h3000_0008);
        run(8);
        chk("full", fq_count_o, 4);
        chk("full_no_req", ifu_r_valid_o, 0);
        chk("head0", ifu_pc_o, 32'h3000_0000);
        p_pop = 100; run(1); p_pop = 0;
        chk("head1", ifu_pc_o, 32'h3000_0004);
        run(3);
        chk("one_slot_no_req", ifu_r_valid_o, 0);
        p_ar = 0; p_pop = 100; run(1); p_pop = 0;
        wait_req(10, "req_after_pops");
        chk("third_req", ifu_r_addr_o, 32'h3000_0010);
        // redirect on the first beat of a burst
        p_ar = 100; run(1); p_ar = 0;
        drive_auto(); redirect_valid = 1'b1; redirect_pc = 32'h8000_0002; tick();
        chk("redir_flush", fq_count_o, 0);
        drive_auto(); tick();
        chk("drained_empty", fq_count_o, 0);
        wait_req(10, "req_after_redir");
        chk("redir_addr", ifu_r_addr_o, 32'h8000_0000);
        // redirect while the request waits for acceptance
        drive_auto(); redirect_valid = 1'b1; redirect_pc = 32'h3000_0008; tick();
        for (int i = 0; i < 3; i++) begin
            run(1);
            chk("held_addr", ifu_r_addr_o, 32'h8000_0000);
        end
        p_ar = 100; run(1); p_ar = 0;
        wait_req(10, "req_after_drain");
        chk("req_redir_addr", ifu_r_addr_o, 32'h3000_0008);
        chk("drain_empty", fq_count_o, 0);
        // bus error on the first beat
        p_ar = 100; run(1);
        drive_auto(); ifu_r_err_i = 1'b1; tick();
        drive_auto(); tick();
        chk("err_count", fq_count_o, 1);
        chk("err_fault", ifu_fault_o, 1);
        chk("err_pc", ifu_pc_o, 32'h3000_0008);
        run(10);
        chk("halt_no_req", ifu_r_valid_o, 0);
        chk("halt_count", fq_count_o, 1);
        p_ar = 0;
        drive_auto(); redirect_valid = 1'b1; redirect_pc = 32'h3000_0100; tick();
        chk("halt_flush", fq_count_o, 0);
        wait_req(10, "req_after_halt");
        chk("halt_redir_addr", ifu_r_addr_o, 32'h3000_0100);
        // push, pop and redirect together
        p_ar = 100; run(1);
        drive_auto(); tick();
        chk("one_entry", fq_count_o, 1);
        drive_auto(); ifu_ready_i = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h4000_0000; tick();
        chk("ppr_count", fq_count_o, 0);
        chk("ppr_valid", ifu_valid_o, 0);
        p_ar = 0;
        wait_req(10, "req_after_ppr");
        chk("ppr_addr", ifu_r_addr_o, 32'h4000_0000);
        // randomized traffic, then a reset in the middle of it
        p_ar = 60; p_r = 70; p_redir = 3; p_err = 2; p_pop = 50;
        run(3000);
        p_redir = 0;
        do_reset();
        p_redir = 3;
        run(1000);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
